// File: rtl/uivbuf_sched_if.sv
// Handshake bundle between the frame writer/reader and the buffer scheduler.
// master drives the frame pulses, slave returns the buffer indices and status.
interface uivbuf_sched_if #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
);
    logic             wr_fs_i;
    logic             wr_fe_i;
    logic             rd_fs_i;
    logic [IDX_W-1:0] wr_bufn_o;
    logic [IDX_W-1:0] rd_bufn_o;
    logic             rd_new_o;
    logic             wr_busy_o;
    logic             err_o;
    logic [CNT_W-1:0] drop_cnt_o;

    modport master (
        output wr_fs_i, wr_fe_i, rd_fs_i,
        input  wr_bufn_o, rd_bufn_o, rd_new_o,
        input  wr_busy_o, err_o, drop_cnt_o
    );

    modport slave (
        input  wr_fs_i, wr_fe_i, rd_fs_i,
        output wr_bufn_o, rd_bufn_o, rd_new_o,
        output wr_busy_o, err_o, drop_cnt_o
    );
endinterface

// File: rtl/uivbuf_sched.sv
// Triple-buffer scheduler: rotates write/read/spare indices so the reader
// always gets the newest completed frame and never shares the writer's buffer.
module uivbuf_sched #(
    parameter int          IDX_W   = 8,
    parameter int          CNT_W   = 16,
    parameter int unsigned IDX_WR0 = 0,
    parameter int unsigned IDX_RD0 = 1,
    parameter int unsigned IDX_SP0 = 2
) (
    input  logic           ui_clk,
    input  logic           ui_rstn,
    uivbuf_sched_if.slave  bus
);

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wstate_e;

    wstate_e          state_q, state_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic [IDX_W-1:0] sp_q, sp_d;
    logic             rv_q, rv_d;
    logic             new_q, new_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             cmp;

    always_ff @(posedge ui_clk) begin
        if (!ui_rstn) begin
            state_q <= W_IDLE;
            wr_q    <= IDX_W'(IDX_WR0);
            rd_q    <= IDX_W'(IDX_RD0);
            sp_q    <= IDX_W'(IDX_SP0);
            rv_q    <= 1'b0;
            new_q   <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            sp_q    <= sp_d;
            rv_q    <= rv_d;
            new_q   <= new_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    // Writer protocol; fs+fe while active closes one frame and opens the next.
    always_comb begin
        state_d = state_q;
        cmp     = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                if (bus.wr_fs_i) state_d = W_ACTIVE;
                err_d = bus.wr_fe_i;
            end
            W_ACTIVE: begin
                if (bus.wr_fe_i) begin
                    cmp     = 1'b1;
                    state_d = bus.wr_fs_i ? W_ACTIVE : W_IDLE;
                end else if (bus.wr_fs_i) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Index rotation; a pending spare frame overwritten counts as a drop.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        sp_d   = sp_q;
        rv_d   = rv_q;
        new_d  = 1'b0;
        drop_d = drop_q;
        if (cmp && bus.rd_fs_i) begin
            rd_d  = wr_q;
            wr_d  = sp_q;
            sp_d  = rd_q;
            rv_d  = 1'b0;
            new_d = 1'b1;
        end else if (cmp) begin
            wr_d = sp_q;
            sp_d = wr_q;
            rv_d = 1'b1;
        end else if (bus.rd_fs_i && rv_q) begin
            rd_d  = sp_q;
            sp_d  = rd_q;
            rv_d  = 1'b0;
            new_d = 1'b1;
        end
        if (cmp && rv_q && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    assign bus.wr_bufn_o  = wr_q;
    assign bus.rd_bufn_o  = rd_q;
    assign bus.rd_new_o   = new_q;
    assign bus.wr_busy_o  = (state_q == W_ACTIVE);
    assign bus.err_o      = err_q;
    assign bus.drop_cnt_o = drop_q;

endmodule

// File: tb/tb_uivbuf_sched.sv
// Vector table plus scoreboard for the triple-buffer scheduler,
// with a narrow-counter instance for drop saturation.
module tb_uivbuf_sched;

    logic ui_clk  = 1'b0;
    logic ui_rstn = 1'b0;
    always #5 ui_clk = ~ui_clk;

    uivbuf_sched_if #(.IDX_W(8), .CNT_W(16)) m_if ();
    uivbuf_sched_if #(.IDX_W(8), .CNT_W(2))  s_if ();

    uivbuf_sched #(.IDX_W(8), .CNT_W(16)) u_dut (
        .ui_clk  (ui_clk),
        .ui_rstn (ui_rstn),
        .bus     (m_if.slave)
    );

    uivbuf_sched #(.IDX_W(8), .CNT_W(2)) u_sat (
        .ui_clk  (ui_clk),
        .ui_rstn (ui_rstn),
        .bus     (s_if.slave)
    );

    typedef struct {
        logic        rst, fs, fe, rd;
        logic [7:0]  wr, rdb;
        logic        nw, busy, err;
        logic [15:0] drop;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  wr, rdb;
        logic        nw, busy, err;
        logic [15:0] drop;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(int rst, int fs, int fe, int rd, int wr,
                                int rdb, int nw, int busy, int err, int drop);
        vec_t v;
        v.rst = rst[0]; v.fs = fs[0]; v.fe = fe[0]; v.rd = rd[0];
        v.wr = wr[7:0]; v.rdb = rdb[7:0];
        v.nw = nw[0]; v.busy = busy[0]; v.err = err[0];
        v.drop = drop[15:0];
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        if (m_if.wr_bufn_o !== e.wr || m_if.rd_bufn_o !== e.rdb ||
            m_if.rd_new_o !== e.nw || m_if.wr_busy_o !== e.busy ||
            m_if.err_o !== e.err || m_if.drop_cnt_o !== e.drop) begin
            errors++;
            $display("FAIL vec%0d: got wr=%0d rd=%0d new=%0d busy=%0d err=%0d drop=%0d, want wr=%0d rd=%0d new=%0d busy=%0d err=%0d drop=%0d",
                     e.id, m_if.wr_bufn_o, m_if.rd_bufn_o, m_if.rd_new_o,
                     m_if.wr_busy_o, m_if.err_o, m_if.drop_cnt_o,
                     e.wr, e.rdb, e.nw, e.busy, e.err, e.drop);
        end
        checks++;
        if (m_if.wr_bufn_o === m_if.rd_bufn_o) begin
            errors++;
            $display("FAIL distinct%0d: wr=%0d rd=%0d, want different",
                     e.id, m_if.wr_bufn_o, m_if.rd_bufn_o);
        end
    endtask

    task automatic apply(int id, vec_t v);
        exp_t e;
        @(negedge ui_clk);
        ui_rstn      = ~v.rst;
        m_if.wr_fs_i = v.fs;
        m_if.wr_fe_i = v.fe;
        m_if.rd_fs_i = v.rd;
        e.id = id; e.wr = v.wr; e.rdb = v.rdb;
        e.nw = v.nw; e.busy = v.busy; e.err = v.err; e.drop = v.drop;
        sb.push_back(e);
        @(posedge ui_clk);
        #1;
        check_out();
    endtask

    task automatic sat_pulse(logic fs, logic fe);
        @(negedge ui_clk);
        s_if.wr_fs_i = fs;
        s_if.wr_fe_i = fe;
        @(posedge ui_clk);
        #1;
    endtask

    initial begin
        m_if.wr_fs_i = 1'b0; m_if.wr_fe_i = 1'b0; m_if.rd_fs_i = 1'b0;
        s_if.wr_fs_i = 1'b0; s_if.wr_fe_i = 1'b0; s_if.rd_fs_i = 1'b0;

        //                rst fs fe rd  wr rd nw bz er drop
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  2, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1,  1, 2, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0,  1, 2, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0,  0, 2, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0,  0, 2, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1,  1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 1, 3));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 1, 1, 3));
        tbl.push_back(mk(0, 1, 1, 0,  2, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 1, 1, 1,  1, 2, 1, 1, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  2, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  2, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1,  2, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0,  2, 0, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 2));

        repeat (2) @(posedge ui_clk);
        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        @(negedge ui_clk);
        m_if.wr_fs_i = 1'b0; m_if.wr_fe_i = 1'b0; m_if.rd_fs_i = 1'b0;
        ui_rstn = 1'b0;
        @(negedge ui_clk);
        ui_rstn = 1'b1;

        // Seven unread frames on a 2-bit counter: six drops, held at 3.
        for (int k = 1; k <= 7; k++) begin
            logic [1:0] want;
            sat_pulse(1'b1, 1'b0);
            sat_pulse(1'b0, 1'b1);
            want = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            checks++;
            if (s_if.drop_cnt_o !== want) begin
                errors++;
                $display("FAIL sat_drop%0d: got %0d want %0d",
                         k, s_if.drop_cnt_o, want);
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
